// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path: FSM states,
// frame field offsets and the parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int unsigned START_OFS = 0;

  function automatic int unsigned par_ofs(input int unsigned data_bits);
    return data_bits + 1;
  endfunction

  function automatic int unsigned stop_ofs(input int unsigned data_bits);
    return data_bits + 2;
  endfunction

  // Zero-extension of the data word does not change its XOR reduction.
  function automatic logic parity_ok(input logic [63:0] data, input logic par,
                                     input logic odd);
    return (^{data, par}) == odd;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus run-length glitch filter for one PS/2 pad; both preset
// to the idle-high bus level on reset.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic filt
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   sync_out;

  assign sync_out = sync[SYNC_STAGES-1];

  // filt follows sync_out only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '1;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], line};
      if (sync_out == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync_out;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered line capture, frame checking with
// inter-bit timeout, and a first-word-fall-through byte FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned PARITY_ODD     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             scl,
  input  logic                             sda,
  input  logic                             rd_en,
  output logic                             data_valid,
  output logic [DATA_BITS-1:0]             data_out,
  output logic [DATA_BITS+2:0]             frame_raw,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             parity_err,
  output logic                             frame_err,
  output logic                             overflow
);

  localparam int unsigned FW       = DATA_BITS + 3;
  localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PAR_OFS  = par_ofs(DATA_BITS);
  localparam int unsigned STOP_OFS = stop_ofs(DATA_BITS);

  logic scl_f, sda_f, scl_prev, fall;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .line(scl), .filt(scl_f)
  );

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .line(sda), .filt(sda_f)
  );

  assign fall = scl_prev & ~scl_f;

  state_t               state;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [TW-1:0]        tcnt;
  logic [FW-1:0]        frame_c;
  logic                 par_good_c;
  logic                 push_c;

  always_comb begin
    frame_c              = '0;
    frame_c[START_OFS]   = 1'b0;
    frame_c[DATA_BITS:1] = shift;
    frame_c[PAR_OFS]     = par_bit;
    frame_c[STOP_OFS]    = sda_f;
  end

  assign par_good_c = parity_ok(64'(shift), par_bit, 1'(PARITY_ODD));
  assign push_c     = fall & (state == STOP) & sda_f & par_good_c;

  // Frame capture FSM with inter-bit timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bcnt       <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      scl_prev   <= 1'b1;
      frame_raw  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scl_prev   <= scl_f;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!sda_f) begin
              state <= DATA;
              bcnt  <= '0;
            end
          end
          DATA: begin
            shift[bcnt] <= sda_f;
            if (bcnt == BW'(DATA_BITS - 1)) state <= PARITY;
            else                            bcnt  <= bcnt + 1'b1;
          end
          PARITY: begin
            par_bit <= sda_f;
            state   <= STOP;
          end
          STOP: begin
            frame_raw <= frame_c;
            state     <= IDLE;
            if (!sda_f)           frame_err  <= 1'b1;
            else if (!par_good_c) parity_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr, next_rd_c;
  logic [CW-1:0]        next_count_c;
  logic                 pop_c, do_push_c, ovf_c;
  logic [DATA_BITS-1:0] head_c;

  assign pop_c        = rd_en & (fifo_count != '0);
  assign do_push_c    = push_c & ((fifo_count != CW'(FIFO_DEPTH)) | pop_c);
  assign ovf_c        = push_c & ~do_push_c;
  assign next_count_c = fifo_count + CW'(do_push_c) - CW'(pop_c);
  assign next_rd_c    = pop_c ? rd_ptr + PW'(1) : rd_ptr;

  // Registered FWFT head; a byte written this cycle bypasses the array
  always_comb begin
    head_c = data_out;
    if (next_count_c != '0) begin
      if (do_push_c && (next_rd_c == wr_ptr)) head_c = shift;
      else                                    head_c = mem[next_rd_c];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= next_rd_c;
      fifo_count <= next_count_c;
      data_valid <= (next_count_c != '0);
      data_out   <= head_c;
      overflow   <= ovf_c;
    end
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, the successor of the ps2 frame capture block.
- Synchronises and glitch-filters scl/sda, then captures LSB-first frames on filtered scl falling edges.
- Checks start, parity and stop bits, and enforces an inter-bit timeout.
- Pushes good data bytes into a first-word-fall-through FIFO read by the keyboard/scan-code logic.

Parameters:
DATA_BITS, 8, data bits per frame (frame = DATA_BITS+3 bits).
SYNC_STAGES, 2, flops in each scl/sda synchroniser (>=2).
FILTER_LEN, 4, consecutive equal synchronised samples required before a filtered line changes.
PARITY_ODD, 1, 1 = odd parity (PS/2 standard), 0 = even.
TIMEOUT_CYCLES, 5000, clk cycles without a filtered scl falling edge that abort a frame in progress.
FIFO_DEPTH, 4, byte FIFO entries (power of 2, >=2).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
scl  in  1  PS/2 clock pad, asynchronous.
sda  in  1  PS/2 data pad, asynchronous.
rd_en  in  1  pop FIFO head this cycle.
data_valid  out  1  FIFO not empty.
data_out  out  DATA_BITS  FIFO head (FWFT).
frame_raw  out  DATA_BITS+3  last completed frame, bit0 = start.
fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held.
parity_err  out  1  one-cycle pulse: parity mismatch.
frame_err  out  1  one-cycle pulse: bad stop bit or timeout.
overflow  out  1  one-cycle pulse: good byte dropped, FIFO full.

Behaviour:
- Reset (rst=0, any time including mid-frame):
  - All outputs and fifo_count go to 0; FIFO emptied.
  - Synchronisers and filters are preset to 1 (idle bus).
  - FSM returns to IDLE and the timeout counter clears.
- Filter:
  - scl_f/sda_f change only after FILTER_LEN consecutive cycles of the new synchronised value.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Edge detect: fall = scl_f_prev & ~scl_f. The bit is sampled from sda_f in the same cycle.
- FSM (bit counter bcnt):
  - IDLE: on fall, if sda_f=0 go to DATA with bcnt=0; if sda_f=1 ignore (invalid start) and stay in IDLE.
  - DATA: each fall shifts sda_f into shift[bcnt] (LSB first). After bit DATA_BITS-1 go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, update frame_raw = {stop, parity, data, 1'b0} (1 cycle after the fall), go to IDLE, then evaluate in the same cycle:
    - stop=0: frame_err pulse, no push; parity is not evaluated.
    - stop=1 and parity wrong: parity_err pulse, no push.
    - otherwise: push data.
  - Parity is correct when ^{data,parity} == PARITY_ODD.
- Timeout:
  - Counter clears on every fall and is held at 0 in IDLE.
  - Reaching TIMEOUT_CYCLES-1 outside IDLE: frame_err pulse, go to IDLE, partial data discarded, frame_raw unchanged.
- FIFO:
  - data_valid rises the cycle after the push cycle.
  - rd_en with empty FIFO: ignored.
  - Push while full without rd_en: byte dropped, overflow pulse, contents unchanged.
  - Push and rd_en together when full: both happen, count stays FIFO_DEPTH, no overflow.
  - Push and rd_en together when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency, pad edge to filtered edge: SYNC_STAGES+FILTER_LEN cycles.

Decomposition:
- Package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP), frame field offset constants (START=0, PAR=DATA_BITS+1, STOP=DATA_BITS+2), parity function.
- Sub-module ps2_line_filter (synchroniser + FILTER_LEN filter), instantiated once for scl and once for sda.
- The FIFO stays inline.

Test Plan:
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0; parity 0; stop 1), scl half-period 20 cycles -> frame_raw=0x438, data_valid=1, data_out=0x1C, fifo_count=1, no error pulses; rd_en one cycle -> data_valid=0.
- 0x1C with parity 1 -> parity_err one pulse, frame_raw=0x638, fifo_count=0.
- 2-cycle low glitch on scl during IDLE and mid-DATA (FILTER_LEN=4) -> no bit taken; a following valid 0xF0 (parity 1) gives data_out=0xF0.
- Stop after 5 data bits, wait TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next 0xF0 frame received correctly.
- Five good frames 0x01..0x05, no reads -> overflow pulse on 5th, fifo_count=4; reads yield 0x01,0x02,0x03,0x04. Also rd_en coincident with a push at full -> no overflow.
- rst low for 3 cycles after bit 4 of a frame -> all outputs 0; next full frame 0x5A (parity 1) received as 0x5A.
